// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one combinational ALU between two
// requesters. Each accepted op is registered, drives the ALU for one cycle,
// and its result/flags land in a one-entry response buffer for that port.
module alu_share_arb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result0,
  output logic [WIDTH-1:0] rsp_result1,
  output logic [1:0]       rsp_zero,
  output logic [1:0]       rsp_sign,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_sign,
  output logic             busy
);

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             sign;
  } rsp_t;

  req_t [1:0] port_req;
  logic [1:0] elig, cand, win, cap;

  logic       if_valid_q, if_valid_d;
  logic       if_port_q, if_port_d;
  req_t       if_req_q, if_req_d;
  logic [1:0] rb_valid_q, rb_valid_d;
  rsp_t [1:0] rb_q, rb_d;
  logic       rr_q, rr_d;

  assign port_req[0] = '{op: req_op0, a: req_a0, b: req_b0};
  assign port_req[1] = '{op: req_op1, a: req_a1, b: req_b1};

  // Eligibility and grant: a port may not reissue while its op is in the
  // issue register, nor while its response slot is full and not draining.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      elig[p] = !(if_valid_q && (if_port_q == p[0])) &&
                (!rb_valid_q[p] || rsp_ready[p]);
    end
    cand      = req_valid & elig;
    win[0]    = cand[0] && (!cand[1] || !rr_q);
    win[1]    = cand[1] && (!cand[0] ||  rr_q);
    req_ready = {elig[1] && !win[0], elig[0] && !win[1]};
  end

  // Issue-stage next state; win is one-hot and equals valid & ready.
  always_comb begin
    if_valid_d = 1'b0;
    if_port_d  = if_port_q;
    if_req_d   = if_req_q;
    rr_d       = rr_q;
    if (|win) begin
      if_valid_d = 1'b1;
      if_port_d  = win[1];
      if_req_d   = port_req[win[1]];
      rr_d       = ~win[1];
    end
  end

  // Response buffers: capture from the ALU beats a same-cycle drain.
  always_comb begin
    rb_valid_d = rb_valid_q;
    rb_d       = rb_q;
    for (int p = 0; p < 2; p++) begin
      cap[p] = if_valid_q && (if_port_q == p[0]);
      if (cap[p]) begin
        rb_valid_d[p] = 1'b1;
        rb_d[p]       = '{result: alu_result, zero: alu_zero, sign: alu_sign};
      end else if (rb_valid_q[p] && rsp_ready[p]) begin
        rb_valid_d[p] = 1'b0;
      end
    end
  end

  // State registers; reset discards any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid_q <= 1'b0;
      if_port_q  <= 1'b0;
      if_req_q   <= '0;
      rb_valid_q <= '0;
      rb_q       <= '0;
      rr_q       <= 1'b0;
    end else begin
      if_valid_q <= if_valid_d;
      if_port_q  <= if_port_d;
      if_req_q   <= if_req_d;
      rb_valid_q <= rb_valid_d;
      rb_q       <= rb_d;
      rr_q       <= rr_d;
    end
  end

  // ALU is driven only by a live issue entry, zero otherwise.
  assign alu_op = if_valid_q ? if_req_q.op : 3'd0;
  assign alu_a  = if_valid_q ? if_req_q.a  : '0;
  assign alu_b  = if_valid_q ? if_req_q.b  : '0;

  assign rsp_valid   = rb_valid_q;
  assign rsp_result0 = rb_q[0].result;
  assign rsp_result1 = rb_q[1].result;
  assign rsp_zero    = {rb_q[1].zero, rb_q[0].zero};
  assign rsp_sign    = {rb_q[1].sign, rb_q[0].sign};
  assign busy        = if_valid_q || (|rb_valid_q);

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: a behavioural ALU closes the loop, a per-port
// scoreboard checks every response, and directed steps check timing.
module tb_alu_share_arb;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = '0, req_ready;
  logic [2:0]   req_op0 = '0, req_op1 = '0;
  logic [W-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [1:0]   rsp_valid, rsp_ready = 2'b11;
  logic [W-1:0] rsp_result0, rsp_result1;
  logic [1:0]   rsp_zero, rsp_sign;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_zero, alu_sign, busy;

  int checks = 0, failures = 0;
  logic [W+1:0] q0[$], q1[$];

  alu_share_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_b0(req_b0),
    .req_a1(req_a1), .req_b1(req_b1), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result0(rsp_result0),
    .rsp_result1(rsp_result1), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_sign(alu_sign), .busy(busy));

  always #5 clk = ~clk;

  // 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL, 6 SRL, 7 XOR
  function automatic logic [W-1:0] alu_f(input logic [2:0] op,
                                         input logic [W-1:0] a, b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      3'd5: return a << b[4:0];
      3'd6: return a >> b[4:0];
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [W+1:0] exp_rsp(input logic [2:0] op,
                                           input logic [W-1:0] a, b);
    logic [W-1:0] r;
    r = alu_f(op, a, b);
    return {r, (r == '0), r[W-1]};
  endfunction

  assign alu_result = alu_f(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);
  assign alu_sign   = alu_result[W-1];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: inputs are stable mid-cycle, so sample what the next edge sees.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (rsp_valid[0] && rsp_ready[0]) begin
        if (q0.size() == 0) chk("rsp0_unexpected", 64'(1), 64'(0));
        else chk("rsp0_data", 64'({rsp_result0, rsp_zero[0], rsp_sign[0]}),
                 64'(q0.pop_front()));
      end
      if (rsp_valid[1] && rsp_ready[1]) begin
        if (q1.size() == 0) chk("rsp1_unexpected", 64'(1), 64'(0));
        else chk("rsp1_data", 64'({rsp_result1, rsp_zero[1], rsp_sign[1]}),
                 64'(q1.pop_front()));
      end
      if (req_valid[0] && req_ready[0]) q0.push_back(exp_rsp(req_op0, req_a0, req_b0));
      if (req_valid[1] && req_ready[1]) q1.push_back(exp_rsp(req_op1, req_a1, req_b1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [1:0] acc, prev;
    logic [7:0] rdy_hist;
    int i0, i1, cyc, bad, stuck;
    logic [W-1:0] a0 [8], b0 [8], a1 [8], b1 [8];

    // Reset state
    rst_n = 1'b0;
    tick();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_alu_op", 64'(alu_op), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(2'b11));
    rst_n = 1'b1;
    tick();

    // Single add on port 0
    req_valid = 2'b01; req_op0 = 3'd0; req_a0 = 5; req_b0 = 7;
    #1 chk("add_ready", 64'(req_ready[0]), 64'(1));
    tick();
    req_valid = 2'b00;
    chk("add_alu", 64'({alu_op, alu_a, alu_b}), 64'({3'd0, W'(5), W'(7)}));
    chk("add_no_rsp_yet", 64'(rsp_valid), 64'(0));
    tick();
    chk("add_rsp_valid", 64'(rsp_valid), 64'(2'b01));
    chk("add_rsp", 64'({rsp_result0, rsp_zero[0], rsp_sign[0]}), 64'({W'(12), 2'b00}));
    tick();

    // Contention after reset: port 0 first, then port 1
    do_reset();
    req_valid = 2'b11;
    req_op0 = 3'd1; req_a0 = 3; req_b0 = 3;
    req_op1 = 3'd4; req_a1 = 32'hFFFF_FFFF; req_b1 = 1;
    #1 chk("cont_ready_t", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b10;
    #1 chk("cont_ready_t1", 64'(req_ready), 64'(2'b10));
    tick();
    req_valid = 2'b00;
    chk("cont_rsp0", 64'({rsp_valid[0], rsp_result0, rsp_zero[0]}), 64'({1'b1, W'(0), 1'b1}));
    tick();
    chk("cont_rsp1", 64'({rsp_valid[1], rsp_result1}), 64'({1'b1, W'(1)}));
    tick();

    // Backpressure on port 0 while port 1 keeps issuing
    rsp_ready = 2'b10;
    req_valid = 2'b01; req_op0 = 3'd0; req_a0 = 10; req_b0 = 20;
    tick();
    req_a0 = 1; req_b0 = 1;
    req_valid = 2'b11; req_op1 = 3'd0; req_a1 = 100; req_b1 = 1;
    #1 chk("bp_ready_a", 64'(req_ready), 64'(2'b10));
    tick();
    req_a1 = 200; req_b1 = 2;
    chk("bp_hold_a", 64'({rsp_valid[0], rsp_result0}), 64'({1'b1, W'(30)}));
    chk("bp_ready_b", 64'(req_ready), 64'(2'b00));
    tick();
    chk("bp_ready_c", 64'(req_ready), 64'(2'b10));
    tick();
    req_valid = 2'b01;
    chk("bp_hold_b", 64'({rsp_valid[0], rsp_result0}), 64'({1'b1, W'(30)}));
    rsp_ready = 2'b11;
    #1 chk("bp_release_ready", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    tick();
    chk("bp_new_rsp", 64'({rsp_valid[0], rsp_result0}), 64'({1'b1, W'(2)}));
    tick();
    tick();

    // Alternation throughput: 8 ADDs per port
    for (int k = 0; k < 8; k++) begin
      a0[k] = $urandom; b0[k] = $urandom; a1[k] = $urandom; b1[k] = $urandom;
    end
    i0 = 0; i1 = 0; cyc = 0; bad = 0; prev = 2'b00;
    req_op0 = 3'd0; req_op1 = 3'd0;
    while ((i0 < 8 || i1 < 8) && cyc < 40) begin
      req_valid = {i1 < 8, i0 < 8};
      req_a0 = a0[i0 & 7]; req_b0 = b0[i0 & 7];
      req_a1 = a1[i1 & 7]; req_b1 = b1[i1 & 7];
      #1 acc = req_valid & req_ready;
      if (acc != 2'b01 && acc != 2'b10) bad++;
      if (acc == prev) bad++;
      prev = acc;
      if (acc[0]) i0++;
      if (acc[1]) i1++;
      tick();
      cyc++;
    end
    req_valid = 2'b00;
    chk("alt_cycles", 64'(cyc), 64'(16));
    chk("alt_pattern_bad", 64'(bad), 64'(0));
    tick();
    tick();
    tick();

    // Single-port rate, cycling through all opcodes
    for (int k = 0; k < 8; k++) begin
      req_valid = 2'b01; req_op0 = 3'(k);
      req_a0 = $urandom; req_b0 = $urandom;
      #1 rdy_hist[k] = req_ready[0];
      tick();
    end
    req_valid = 2'b00;
    chk("single_rate", 64'(rdy_hist), 64'(8'b0101_0101));
    tick();
    tick();
    tick();

    // Reset mid-flight
    req_valid = 2'b10; req_op1 = 3'd7; req_a1 = 32'h0F0F_0F0F; req_b1 = 32'h00FF_00FF;
    tick();
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 64'({rsp_valid, alu_op, busy}), 64'(0));
    chk("mid_rst_alu_a", 64'(alu_a), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    stuck = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (rsp_valid != 2'b00) stuck++;
    end
    chk("mid_rst_no_rsp", 64'(stuck), 64'(0));
    req_valid = 2'b11; req_op0 = 3'd3; req_a0 = 8; req_b0 = 1;
    req_op1 = 3'd2; req_a1 = 6; req_b1 = 3;
    #1 chk("mid_rst_first_grant", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) tick();

    chk("q0_empty", 64'(q0.size()), 64'(0));
    chk("q1_empty", 64'(q1.size()), 64'(0));
    chk("end_busy", 64'(busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a wait ever hangs.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
